// File: rtl/leg_length_root.sv
// leg_length_root: Euclidean length floor(sqrt(x^2+y^2+z^2)) of a packed signed 3-vector.
// One shared 17x17 signed multiplier squares a component per cycle. A restoring
// bit-pair square root then produces one result bit per cycle.
// Optional feature macro: LEG_CLAMP_EN clamps leg_length to [LEG_MIN, LEG_MAX]
// and flags out_of_range. Without it the raw root is reported.
module leg_length_root #(
  parameter logic [16:0] LEG_MIN = 17'd0,
  parameter logic [16:0] LEG_MAX = 17'd131071
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [50:0] leg_vector,
  output logic        busy,
  output logic        done,
  output logic [16:0] leg_length,
  output logic [33:0] sq_sum,
  output logic        out_of_range
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SQ   = 2'd1;
  localparam logic [1:0] ROOT = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [50:0] vec_q, vec_d;
  logic [33:0] acc_q, acc_d;
  logic [33:0] rad_q, rad_d;
  logic [18:0] rem_q, rem_d;
  logic [16:0] root_q, root_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [16:0] len_q, len_d;
  logic [33:0] sum_q, sum_d;
  logic        oor_q, oor_d;

  logic signed [16:0] comp;
  logic signed [33:0] comp_ext;
  logic signed [33:0] prod;
  logic [33:0]        acc_next;
  logic [18:0]        rem_t;
  logic [18:0]        trial;
  logic               take;
  logic [16:0]        len_fin;
  logic               oor_fin;

  // Shared datapath: component square and one restoring root step.
  always_comb begin
    comp     = cnt_q == 5'd0 ? vec_q[16:0] : cnt_q == 5'd1 ? vec_q[33:17] : vec_q[50:34];
    comp_ext = {{17{comp[16]}}, comp};
    prod     = comp_ext * comp_ext;
    acc_next = acc_q + {1'b0, prod[32:0]};
    rem_t    = {rem_q[16:0], rad_q[33:32]};
    trial    = {root_q, 2'b01};
    take     = rem_t >= trial;
  end

`ifdef LEG_CLAMP_EN
  // Clamp the finished root into the configured window.
  always_comb begin
    len_fin = root_q < LEG_MIN ? LEG_MIN : root_q > LEG_MAX ? LEG_MAX : root_q;
    oor_fin = (root_q < LEG_MIN) || (root_q > LEG_MAX);
  end
`else
  logic unused_params;
  assign unused_params = ^{LEG_MIN, LEG_MAX};
  // Raw root passes straight through; nothing is ever out of range.
  always_comb begin
    len_fin = root_q;
    oor_fin = 1'b0;
  end
`endif

  // Next-state and register updates for the IDLE/SQ/ROOT/FIN sequence.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    acc_d   = acc_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sum_d   = sum_q;
    oor_d   = oor_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d   = leg_vector;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SQ;
        end
      end
      SQ: begin
        acc_d = acc_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd2) begin
          rad_d   = acc_next;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = '0;
          state_d = ROOT;
        end
      end
      ROOT: begin
        rem_d  = take ? rem_t - trial : rem_t;
        root_d = {root_q[15:0], take};
        rad_d  = {rad_q[31:0], 2'b00};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd16) state_d = FIN;
      end
      default: begin
        len_d   = len_fin;
        sum_d   = acc_q;
        oor_d   = oor_fin;
        state_d = IDLE;
      end
    endcase
    done_d = state_q == FIN;
    busy_d = (state_d != IDLE) || done_d;
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      vec_q   <= '0;
      acc_q   <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      len_q   <= '0;
      sum_q   <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      acc_q   <= acc_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      oor_q   <= oor_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign leg_length   = len_q;
  assign sq_sum       = sum_q;
  assign out_of_range = oor_q;

endmodule
